// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared constants, types and helpers for the convolution datapath
// (window generator and convolution channel).
//
// Contents:
//   DataWidth, InputDim, KernelSize, KernelDim : default geometry
//   pixel_t                                    : one InputDim-channel pixel
//   win_bit_offset(c, k, dw)                   : bit offset of element k of
//                                                channel c on the window bus
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int DataWidth  = 32;
    localparam int InputDim   = 4;
    localparam int KernelSize = 9;
    localparam int KernelDim  = 3;

    typedef logic [InputDim*DataWidth-1:0] pixel_t;

    // Window bus layout: channel-major, then k = 3*row_offset + col_offset.
    // The element width is an argument so instances with a non-default
    // DataWidth share the exact same layout rule.
    function automatic int win_bit_offset(input int c, input int k, input int dw);
        return (c * KernelSize + k) * dw;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
// Enable-gated delay line of Depth entries. On each enabled cycle the oldest
// entry is presented on o_data and i_data is written in its place, so o_data
// is the word written exactly Depth enabled cycles earlier.
// Contents are not cleared by reset; only the circular pointer is.
//
// Ports:
//   i_clk   in   1      clock, rising edge
//   i_rst   in   1      synchronous active-high reset (pointer only)
//   i_en    in   1      advance the delay line this cycle
//   i_data  in   Width  word entering the line
//   o_data  out  Width  word leaving the line (valid while i_en is high)
// -----------------------------------------------------------------------------
module conv_line_buffer #(
    parameter int Depth = 8,
    parameter int Width = 128
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [Width-1:0] i_data,
    output logic [Width-1:0] o_data
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_ptr;

    // Read-before-write: the slot about to be overwritten holds the oldest word.
    assign o_data = r_mem[r_ptr];

    // Circular pointer, advances once per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            if (r_ptr == PtrW'(Depth - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + PtrW'(1);
            end
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Storage write; data is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Turns a raster-order pixel stream into 3x3 sliding windows (no padding)
// for the convolution channel. Two cascaded line buffers supply the two rows
// above the incoming pixel; a 3x3 register array holds the current window.
//
// Optional build macro: WINGEN_STRIDE2_EN
//   defined   : emit only windows whose top-left (r-2, c-2) is even/even
//   undefined : stride 1, every window with r>=2 and c>=2
//
// Ports:
//   Clk           in   1                               clock, rising edge
//   Rst           in   1                               synchronous active-high reset
//   pixel_in      in   InputDim*DataWidth              channel c at [c*DataWidth +: DataWidth]
//   pixel_valid   in   1                               pixel_in accepted this cycle
//   pixel_sof     in   1                               with pixel_valid: pixel is (0,0)
//   window_out    out  InputDim*KernelSize*DataWidth   window bus, see conv_pkg::win_bit_offset
//   window_valid  out  1                               one-cycle strobe
//   frame_done    out  1                               one-cycle strobe after last pixel of frame
// -----------------------------------------------------------------------------
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DataWidth  = conv_pkg::DataWidth,
    parameter int InputDim   = conv_pkg::InputDim,
    parameter int KernelSize = conv_pkg::KernelSize,
    parameter int ImgWidth   = 8,
    parameter int ImgHeight  = 8
) (
    input  logic                                   Clk,
    input  logic                                   Rst,
    input  logic [InputDim*DataWidth-1:0]          pixel_in,
    input  logic                                   pixel_valid,
    input  logic                                   pixel_sof,
    output logic [InputDim*KernelSize*DataWidth-1:0] window_out,
    output logic                                   window_valid,
    output logic                                   frame_done
);

    localparam int PixW = InputDim * DataWidth;
    localparam int WinW = InputDim * KernelSize * DataWidth;
    localparam int ColW = $clog2(ImgWidth);
    localparam int RowW = $clog2(ImgHeight);

    if (KernelSize != 9) begin : g_bad_kernel
        $error("conv_window_gen: KernelSize must be 9 (3x3)");
    end
    if (ImgWidth < 3 || ImgHeight < 3) begin : g_bad_image
        $error("conv_window_gen: ImgWidth and ImgHeight must be >= 3");
    end

    logic            w_accept;
    logic [ColW-1:0] r_col;
    logic [RowW-1:0] r_row;
    logic [ColW-1:0] w_col;
    logic [RowW-1:0] w_row;
    logic [ColW-1:0] w_col_nxt;
    logic [RowW-1:0] w_row_nxt;
    logic            w_last_col;
    logic            w_last_row;
    logic            w_stride_ok;
    logic            w_emit;
    logic [PixW-1:0] w_lb0_out;
    logic [PixW-1:0] w_lb1_out;
    logic [PixW-1:0] r_win     [KernelDim][KernelDim];
    logic [PixW-1:0] w_win_nxt [KernelDim][KernelDim];
    logic [WinW-1:0] w_win_flat;

    assign w_accept = pixel_valid & ~Rst;

    // Position of the pixel on the bus: sof overrides the running counters.
    always_comb begin
        if (pixel_sof) begin
            w_row = '0;
            w_col = '0;
        end else begin
            w_row = r_row;
            w_col = r_col;
        end
    end

    // Raster advance from the current pixel position.
    always_comb begin
        w_last_col = (w_col == ColW'(ImgWidth - 1));
        w_last_row = (w_row == RowW'(ImgHeight - 1));
        if (w_last_col) begin
            w_col_nxt = '0;
            if (w_last_row) begin
                w_row_nxt = '0;
            end else begin
                w_row_nxt = w_row + RowW'(1);
            end
        end else begin
            w_col_nxt = w_col + ColW'(1);
            w_row_nxt = w_row;
        end
    end

    // Row/column counters, held during gaps.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end else begin
            r_row <= r_row;
            r_col <= r_col;
        end
    end

    // lb0 delays by one row (pixel directly above), lb1 by two rows.
    conv_line_buffer #(
        .Depth (ImgWidth),
        .Width (PixW)
    ) u_lb0 (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_en   (w_accept),
        .i_data (pixel_in),
        .o_data (w_lb0_out)
    );

    conv_line_buffer #(
        .Depth (ImgWidth),
        .Width (PixW)
    ) u_lb1 (
        .i_clk  (Clk),
        .i_rst  (Rst),
        .i_en   (w_accept),
        .i_data (w_lb0_out),
        .o_data (w_lb1_out)
    );

    // Window after this pixel: shift left, new right column is {top, mid, bottom}.
    // The output register samples this next-state so the emitted window
    // already contains the pixel just accepted.
    always_comb begin
        for (int i = 0; i < KernelDim; i++) begin
            for (int j = 0; j < KernelDim - 1; j++) begin
                w_win_nxt[i][j] = r_win[i][j+1];
            end
        end
        w_win_nxt[0][KernelDim-1] = w_lb1_out;
        w_win_nxt[1][KernelDim-1] = w_lb0_out;
        w_win_nxt[2][KernelDim-1] = pixel_in;
    end

    // Window register array, data only (stale contents are never emitted).
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_win <= w_win_nxt;
        end
    end

    // Flatten the next window into the channel-major bus layout.
    always_comb begin
        w_win_flat = '0;
        for (int c = 0; c < InputDim; c++) begin
            for (int i = 0; i < KernelDim; i++) begin
                for (int j = 0; j < KernelDim; j++) begin
                    w_win_flat[win_bit_offset(c, KernelDim*i + j, DataWidth) +: DataWidth] =
                        w_win_nxt[i][j][c*DataWidth +: DataWidth];
                end
            end
        end
    end

    // Stride selection: (r-2),(c-2) even is the same as r,c even.
`ifdef WINGEN_STRIDE2_EN
    assign w_stride_ok = ~w_row[0] & ~w_col[0];
`else
    assign w_stride_ok = 1'b1;
`endif

    // A full 3x3 neighbourhood exists once two rows and two columns precede.
    always_comb begin
        if (w_accept && (w_row >= RowW'(2)) && (w_col >= ColW'(2)) && w_stride_ok) begin
            w_emit = 1'b1;
        end else begin
            w_emit = 1'b0;
        end
    end

    // Registered outputs; window_out holds between windows.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            window_out   <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= w_emit;
            frame_done   <= w_accept & w_last_row & w_last_col;
            if (w_emit) begin
                window_out <= w_win_flat;
            end else begin
                window_out <= window_out;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
// Self-checking bench: a frame-image reference model tracks the raster
// position of every accepted pixel, stores it in a 2-D image, and rebuilds the
// expected 3x3 window directly from that image.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

    localparam int DW   = 32;
    localparam int ID   = 4;
    localparam int KS   = 9;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int PixW = ID * DW;
    localparam int WinW = ID * KS * DW;
`ifdef WINGEN_STRIDE2_EN
    localparam int Stride = 2;
`else
    localparam int Stride = 1;
`endif
    localparam int WinPerFrame = ((W - 2 + Stride - 1) / Stride) * ((H - 2 + Stride - 1) / Stride);

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic [PixW-1:0] pixel_in = '0;
    logic            pixel_valid = 1'b0;
    logic            pixel_sof = 1'b0;
    logic [WinW-1:0] window_out;
    logic            window_valid;
    logic            frame_done;

    always #5 Clk = ~Clk;

    conv_window_gen #(
        .DataWidth  (DW),
        .InputDim   (ID),
        .KernelSize (KS),
        .ImgWidth   (W),
        .ImgHeight  (H)
    ) u_dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_sof    (pixel_sof),
        .window_out   (window_out),
        .window_valid (window_valid),
        .frame_done   (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_win    = 0;

    // Reference model state
    int              m_row = 0;
    int              m_col = 0;
    logic [PixW-1:0] img [H][W];
    logic [WinW-1:0] exp_win   = '0;
    logic            exp_valid = 1'b0;
    logic            exp_done  = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_win(input string tag, input logic [WinW-1:0] obs, input logic [WinW-1:0] expv);
        int wi;
        wi = 0;
        n_checks++;
        assert (obs === expv) else begin
            for (int i = ID*KS - 1; i >= 0; i--) begin
                if (obs[i*DW +: DW] !== expv[i*DW +: DW]) wi = i;
            end
            n_errors++;
            $error("FAIL %s: word %0d got %h expected %h", tag, wi, obs[wi*DW +: DW], expv[wi*DW +: DW]);
        end
    endtask

    function automatic logic [PixW-1:0] pat(input int r, input int c);
        logic [PixW-1:0] p;
        for (int ch = 0; ch < ID; ch++) p[ch*DW +: DW] = DW'(16*ch + W*r + c);
        return p;
    endfunction

    function automatic logic [PixW-1:0] rnd_pix();
        logic [PixW-1:0] p;
        for (int ch = 0; ch < ID; ch++) p[ch*DW +: DW] = $urandom;
        return p;
    endfunction

    // One clock: drive on negedge, update model, check #1 after the posedge.
    task automatic step(input logic v, input logic s, input logic [PixW-1:0] p, input logic rst);
        @(negedge Clk);
        Rst = rst;
        pixel_valid = v;
        pixel_sof = s;
        pixel_in = p;
        if (rst) begin
            m_row = 0;
            m_col = 0;
            exp_valid = 1'b0;
            exp_done = 1'b0;
            exp_win = '0;
        end else begin
            exp_valid = 1'b0;
            exp_done = 1'b0;
            if (v) begin
                if (s) begin
                    m_row = 0;
                    m_col = 0;
                end
                img[m_row][m_col] = p;
                if (m_row >= 2 && m_col >= 2 && ((m_row - 2) % Stride) == 0 && ((m_col - 2) % Stride) == 0) begin
                    exp_valid = 1'b1;
                    for (int c = 0; c < ID; c++)
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                exp_win[(c*KS + 3*i + j)*DW +: DW] = img[m_row-2+i][m_col-2+j][c*DW +: DW];
                end
                if (m_row == H-1 && m_col == W-1) exp_done = 1'b1;
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == H) m_row = 0;
                end
            end
        end
        @(posedge Clk);
        #1;
        check_bit("window_valid", window_valid, exp_valid);
        check_bit("frame_done", frame_done, exp_done);
        check_win("window_out", window_out, exp_win);
        if (window_valid) n_win++;
    endtask

    // gap_mode: 0 none, 1 one idle cycle before each pixel, 2 random 0..2 idle cycles
    task automatic send_pixels(input bit sof_first, input int npix, input int gap_mode, input bit use_pat);
        int ng;
        for (int idx = 0; idx < npix; idx++) begin
            ng = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(2)) : 0;
            repeat (ng) step(1'b0, 1'($urandom_range(1)), rnd_pix(), 1'b0);
            step(1'b1, sof_first && (idx == 0), use_pat ? pat(idx / W, idx % W) : rnd_pix(), 1'b0);
        end
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Continuous pattern frame with sof; spot-check one packed element
        n_win = 0;
        for (int idx = 0; idx < W*H; idx++) begin
            step(1'b1, idx == 0, pat(idx / W, idx % W), 1'b0);
            if (idx == 2*W + 2) begin
                check_int("ch2_k4_first_window", int'(window_out[(2*KS + 4)*DW +: DW]), 16*2 + W*1 + 1);
            end
        end
        check_int("win_count_continuous", n_win, WinPerFrame);

        // Same frame with idle cycles between pixels
        n_win = 0;
        send_pixels(1'b1, W*H, 1, 1'b1);
        check_int("win_count_gaps", n_win, WinPerFrame);

        // Aborted partial frame then a fresh random frame
        send_pixels(1'b1, W + 2, 0, 1'b0);
        n_win = 0;
        send_pixels(1'b1, W*H, 0, 1'b0);
        check_int("win_count_after_abort", n_win, WinPerFrame);

        // Reset in the middle of a frame, then a full frame without sof
        send_pixels(1'b1, 6, 0, 1'b0);
        step(1'b0, 1'b0, rnd_pix(), 1'b1);
        step(1'b0, 1'b0, rnd_pix(), 1'b1);
        n_win = 0;
        send_pixels(1'b0, W*H, 0, 1'b0);
        check_int("win_count_after_reset", n_win, WinPerFrame);

        // Random frames with random gaps, back to back without sof
        for (int f = 0; f < 4; f++) begin
            n_win = 0;
            send_pixels(f == 0, W*H, 2, 1'b0);
            check_int("win_count_random", n_win, WinPerFrame);
        end

        // Drain: outputs must drop and window_out must hold
        step(1'b0, 1'b0, rnd_pix(), 1'b0);
        step(1'b0, 1'b1, rnd_pix(), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
